poli_crc_engine: RTL
====================

# poli_crc_engine

Bit-serial 32-bit CRC engine for the polymorphic CRC peripheral. It sits directly downstream of the APB control-register block. It consumes CRC_CONTROL writes, the CRC_CONFIG polynomial and CRC_INPUT data words, and produces the CRC_OUTPUT and CRC_STATUS read values. It processes one data bit per clock, MSB-first and non-reflected, and buffers one word so software can post a second word while the engine is busy.

## Interface
Parameters:
- WORD_SIZE, 32, data/CRC width; only 32 is supported
- CRC_INIT, 32'hFFFF_FFFF, seed loaded by INIT

Ports (synchronous reset, active-low, single clock):
- CLK  in  1  clock; all state updates on the rising edge
- nRST  in  1  synchronous active-low reset
- ctrl_wr  in  1  one-cycle strobe: CRC_CONTROL written
- ctrl_wdata  in  32  CRC_CONTROL write data; bit0 INIT, bit1 FINAL_XOR
- poly  in  32  CRC_CONFIG value; implicit x^32 term; static while busy
- in_wr  in  1  one-cycle strobe: CRC_INPUT written
- in_wdata  in  32  CRC_INPUT write data
- crc_output  out  32  CRC_OUTPUT read value
- crc_status  out  32  bit0 BUSY, bit1 PENDING, bit2 OVERFLOW (sticky), bit3 DONE; bits 31:4 are 0

## Operation
- **State registers:**
  - crc_reg: 32 bits
  - shift_reg: 32 bits
  - bit_cnt: 5 bits
  - hold_reg plus hold_valid: 32 + 1 bits
  - final_xor: 1 bit
  - overflow, done: 1 bit each
  - FSM: IDLE, SHIFT
- **Reset (nRST low at an edge):** crc_reg = CRC_INIT, all other state = 0, FSM = IDLE. Outputs after reset: crc_output = 32'hFFFF_FFFF, crc_status = 0.
- **Shift step (SHIFT state, each cycle):**
  - fb = crc_reg[31] ^ shift_reg[31]
  - crc_reg <= (crc_reg << 1) ^ (fb ? poly : 0)
  - shift_reg <= shift_reg << 1
  - bit_cnt <= bit_cnt + 1 (wraps 31 -> 0)
- **crc_output** = final_xor ? ~crc_reg : crc_reg. It is combinational from registers and updates every shift cycle. It is only meaningful when BUSY = 0.
- **IDLE -> SHIFT:** on in_wr. The engine loads shift_reg = in_wdata, sets bit_cnt = 0 and clears done.
- **SHIFT, bit_cnt == 31 (last step):**
  - If hold_valid: load shift_reg = hold_reg, clear hold_valid, stay in SHIFT (no bubble).
  - Else if in_wr: load in_wdata directly, stay in SHIFT.
  - Else: go to IDLE and set done.
- **in_wr while in SHIFT:**
  - If hold_valid = 0, or the hold word is consumed this same edge: write hold_reg and set hold_valid.
  - Otherwise: drop the word and set overflow.
- **ctrl_wr with bit0 (INIT) = 1:**
  - crc_reg = CRC_INIT; FSM goes to IDLE.
  - Clear hold_valid, overflow, done and bit_cnt. This aborts any computation in progress.
- **ctrl_wr (any bit0):** latches final_xor = bit1.
- **Priority:** INIT beats a simultaneous in_wr; the word is dropped and OVERFLOW is not set. nRST beats everything.
- **Status bits:** BUSY = (FSM == SHIFT). PENDING = hold_valid. DONE stays set until the next accepted word or INIT.
- **Chaining:** successive words chain onto crc_reg. Only INIT or reset reseeds it.

## Timing
- in_wr sampled at edge k in IDLE: BUSY = 1 after edge k. The 32 shift steps occur at edges k+1..k+32. The final crc_output is valid and BUSY = 0, DONE = 1 after edge k+32. Latency is 32 cycles.
- Back-to-back words through the hold register run without a bubble, so N words take 32·N cycles after the first strobe.
- INIT takes effect after a single edge; status reads 0 in the next cycle.
- poly changes while BUSY = 1 are undefined; software must not make them.

## Structure
- Add the following to POLI_types_pkg:
  - crc_state_t enum (IDLE, SHIFT)
  - CRC_INIT_VALUE
  - Control bit indices: CRC_CTRL_INIT = 0, CRC_CTRL_FXOR = 1
  - Status bit indices: CRC_STAT_BUSY = 0, CRC_STAT_PEND = 1, CRC_STAT_OVF = 2, CRC_STAT_DONE = 3
- Single module, no sub-modules. The hold register and the shift step are inline.

## Test plan
- **Reset:** hold nRST low for 2 cycles, then release -> crc_output = FFFFFFFF and crc_status = 0.
- **Single word:**
  - poly = 04C11DB7, INIT, write FFFFFFFE -> BUSY for 32 cycles, then crc_output = 04C11DB7, status = 0x8.
  - Repeat with FINAL_XOR = 1 -> FB3EE248.
- **Poly-independent case:** write FFFFFFFF from the seed -> 00000000 for any poly. Write FFFFFFFD with poly = 04C11DB7 -> 09823B6E.
- **Back-to-back words:**
  - Write FFFFFFFE, then write 04C11DB6 at cycle 5 -> PENDING = 1 until edge k+32, no idle cycle between words, final output 04C11DB7 after edge k+64.
  - Third write while PENDING -> word dropped, OVERFLOW = 1, result unchanged.
- **INIT mid-computation:** INIT at shift step 10 -> crc_output = FFFFFFFF and status = 0 next cycle. A following write of FFFFFFFE -> 04C11DB7.
- **Last-step collision:** in_wr exactly at bit_cnt == 31 with the hold register empty -> word loaded directly, no overflow, no bubble.

Source files
------------

// File: rtl/poli_crc_engine_pkg.sv
// poli_crc_engine_pkg: shared types and register bit indices for the CRC engine
package poli_crc_engine_pkg;
   typedef enum logic {IDLE, SHIFT} crc_state_t;
   localparam logic [31:0] CRC_INIT_VALUE = 32'hFFFF_FFFF;
   localparam int CRC_CTRL_INIT = 0;
   localparam int CRC_CTRL_FXOR = 1;
   localparam int CRC_STAT_BUSY = 0;
   localparam int CRC_STAT_PEND = 1;
   localparam int CRC_STAT_OVF  = 2;
   localparam int CRC_STAT_DONE = 3;
endpackage

// File: rtl/poli_crc_engine.sv
// poli_crc_engine: bit-serial MSB-first 32-bit CRC with a one-word hold buffer
module poli_crc_engine
   import poli_crc_engine_pkg::*;
#(
   parameter int WORD_SIZE = 32,
   parameter logic [WORD_SIZE-1:0] CRC_INIT = CRC_INIT_VALUE
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 ctrl_wr,
   input  logic [WORD_SIZE-1:0] ctrl_wdata,
   input  logic [WORD_SIZE-1:0] poly,
   input  logic                 in_wr,
   input  logic [WORD_SIZE-1:0] in_wdata,
   output logic [WORD_SIZE-1:0] crc_output,
   output logic [WORD_SIZE-1:0] crc_status
);
   crc_state_t state, state_next;
   logic [WORD_SIZE-1:0] crc_reg, shift_reg, hold_reg, crc_step;
   logic [4:0] bit_cnt;
   logic hold_valid, final_xor, overflow, done;
   logic init, busy, last, fb, start, consume, direct, finish, hold_wr, ovf_set;
   logic unused_ctrl;
   assign unused_ctrl = ^ctrl_wdata[WORD_SIZE-1:2];
   always_comb begin
      init       = ctrl_wr & ctrl_wdata[CRC_CTRL_INIT];
      busy       = state == SHIFT;
      last       = &bit_cnt;
      fb         = crc_reg[WORD_SIZE-1] ^ shift_reg[WORD_SIZE-1];
      crc_step   = (crc_reg << 1) ^ (fb ? poly : '0);
      start      = !init & !busy & in_wr;
      consume    = !init & busy & last & hold_valid;
      direct     = !init & busy & last & !hold_valid & in_wr;
      finish     = !init & busy & last & !hold_valid & !in_wr;
      // at the last step a pending word frees the hold slot on this same edge
      hold_wr    = !init & busy & in_wr & (last ? hold_valid : !hold_valid);
      ovf_set    = !init & busy & in_wr & !last & hold_valid;
      state_next = init ? IDLE : start ? SHIFT : finish ? IDLE : state;
   end
   always_ff @(posedge CLK) begin
      if (!nRST) state <= IDLE;
      else state <= state_next;
   end
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         crc_reg    <= CRC_INIT;
         shift_reg  <= '0;
         hold_reg   <= '0;
         bit_cnt    <= '0;
         hold_valid <= 1'b0;
         final_xor  <= 1'b0;
         overflow   <= 1'b0;
         done       <= 1'b0;
      end else begin
         if (ctrl_wr) final_xor <= ctrl_wdata[CRC_CTRL_FXOR];
         if (init) begin
            crc_reg    <= CRC_INIT;
            bit_cnt    <= '0;
            hold_valid <= 1'b0;
            overflow   <= 1'b0;
            done       <= 1'b0;
         end else if (start) begin
            shift_reg <= in_wdata;
            bit_cnt   <= '0;
            done      <= 1'b0;
         end else if (busy) begin
            crc_reg   <= crc_step;
            bit_cnt   <= bit_cnt + 5'd1;
            shift_reg <= consume ? hold_reg : direct ? in_wdata : shift_reg << 1;
            if (consume) hold_valid <= 1'b0;
            if (hold_wr) begin
               hold_reg   <= in_wdata;
               hold_valid <= 1'b1;
            end
            if (ovf_set) overflow <= 1'b1;
            if (finish) done <= 1'b1;
         end
      end
   end
   assign crc_output = final_xor ? ~crc_reg : crc_reg;
   always_comb begin
      crc_status = '0;
      crc_status[CRC_STAT_BUSY] = busy;
      crc_status[CRC_STAT_PEND] = hold_valid;
      crc_status[CRC_STAT_OVF]  = overflow;
      crc_status[CRC_STAT_DONE] = done;
   end
endmodule
